// File: rtl/cp0_intc_if.sv
// CP0 / interrupt-controller bus: the execute/fetch side (master) drives
// register accesses and interrupt handshakes, the controller (slave) returns
// mfc0 data and the interrupt request.
interface cp0_intc_if #(
   parameter int NUM_IRQ = 4
) ();
   logic                stall;
   logic [NUM_IRQ-1:0]  irq_in;
   logic [4:0]          reg_addr;
   logic                we;
   logic [31:0]         wdata;
   logic [31:0]         rdata;
   logic [31:0]         epc_in;
   logic                int_ack;
   logic                eret;
   logic                int_req;

   modport master (
      output stall, irq_in, reg_addr, we, wdata, epc_in, int_ack, eret,
      input  rdata, int_req
   );

   modport slave (
      input  stall, irq_in, reg_addr, we, wdata, epc_in, int_ack, eret,
      output rdata, int_req
   );
endinterface

// File: rtl/cp0_intc.sv
// Coprocessor-0 register file and interrupt controller for the MIPS150
// pipeline. NUM_IRQ external lines (edge- or level-sensitive per line) map to
// Cause.IP[2+i]; an optional Count/Compare timer drives Cause.IP[7]/TI.
// Interrupt sampling, edge latching, Count and TI keep running under stall so
// no events are lost; all software-visible updates are gated by stall.
module cp0_intc #(
   parameter int                 NUM_IRQ   = 4,
   parameter logic [NUM_IRQ-1:0] EDGE_MASK = {NUM_IRQ{1'b1}},
   parameter bit                 TIMER_EN  = 1'b1
) (
   input logic        clk,
   input logic        rst,
   cp0_intc_if.slave  bus
);

   localparam logic [4:0] ADDR_COUNT   = 5'd9;
   localparam logic [4:0] ADDR_COMPARE = 5'd11;
   localparam logic [4:0] ADDR_STATUS  = 5'd12;
   localparam logic [4:0] ADDR_CAUSE   = 5'd13;
   localparam logic [4:0] ADDR_EPC     = 5'd14;

   // Architectural and sampling state
   logic [NUM_IRQ-1:0] irq_s_q,    irq_s_d;
   logic [NUM_IRQ-1:0] irq_prev_q, irq_prev_d;
   logic [NUM_IRQ-1:0] pend_q,     pend_d;
   logic [31:0]        count_q,    count_d;
   logic [31:0]        compare_q,  compare_d;
   logic [31:0]        epc_q,      epc_d;
   logic               ti_q,       ti_d;
   logic               ie_q,       ie_d;
   logic               exl_q,      exl_d;
   logic [7:0]         im_q,       im_d;
   logic [1:0]         ip_sw_q,    ip_sw_d;

   // Decoded controls and derived values
   logic               wr_s;
   logic               eret_s;
   logic               ack_s;
   logic               wr_count_s;
   logic               wr_compare_s;
   logic               wr_status_s;
   logic               wr_cause_s;
   logic               wr_epc_s;
   logic [NUM_IRQ-1:0] edge_s;
   logic [NUM_IRQ-1:0] clr_s;
   logic               match_s;
   logic [4:0]         hw_ip_s;
   logic               timer_ip_s;
   logic [7:0]         ip_s;
   logic               int_req_s;
   logic [31:0]        rdata_s;

   // Per-line IP source: latched pend bit for edge lines, live sample for level lines;
   // unused IP slots above NUM_IRQ read as zero.
   for (genvar g = 0; g < 5; g++) begin : g_hw_ip
      if (g < NUM_IRQ) begin : g_used
         assign hw_ip_s[g] = EDGE_MASK[g] ? pend_q[g] : irq_s_q[g];
      end else begin : g_unused
         assign hw_ip_s[g] = 1'b0;
      end
   end

   assign timer_ip_s = TIMER_EN ? ti_q : 1'b0;
   assign ip_s       = {timer_ip_s, hw_ip_s, ip_sw_q};
   assign int_req_s  = ie_q & ~exl_q & (|(ip_s & im_q));

   // Decode stall-qualified software strobes and the acknowledge condition
   always_comb begin
      wr_s         = bus.we & ~bus.stall;
      eret_s       = bus.eret & ~bus.stall;
      ack_s        = bus.int_ack & ~bus.stall & int_req_s;
      wr_count_s   = wr_s & (bus.reg_addr == ADDR_COUNT);
      wr_compare_s = wr_s & (bus.reg_addr == ADDR_COMPARE);
      wr_status_s  = wr_s & (bus.reg_addr == ADDR_STATUS);
      wr_cause_s   = wr_s & (bus.reg_addr == ADDR_CAUSE);
      wr_epc_s     = wr_s & (bus.reg_addr == ADDR_EPC);
   end

   // Input sampling and edge-pending bits; a new edge beats a same-cycle clear
   always_comb begin
      irq_s_d    = bus.irq_in;
      irq_prev_d = irq_s_q;
      edge_s     = irq_s_q & ~irq_prev_q & EDGE_MASK;
      if (wr_cause_s) begin
         clr_s = ~bus.wdata[10 +: NUM_IRQ] & EDGE_MASK;
      end else begin
         clr_s = {NUM_IRQ{1'b0}};
      end
      pend_d = (pend_q & ~clr_s) | edge_s;
   end

   // Count/Compare timer: free-running count, sticky TI, Compare write clears TI
   always_comb begin
      match_s = (count_q == compare_q);
      if (!TIMER_EN) begin
         count_d   = 32'd0;
         compare_d = 32'hFFFF_FFFF;
         ti_d      = 1'b0;
      end else begin
         if (wr_count_s) begin
            count_d = bus.wdata;
         end else begin
            count_d = count_q + 32'd1;
         end
         if (wr_compare_s) begin
            compare_d = bus.wdata;
            ti_d      = 1'b0;
         end else if (match_s) begin
            compare_d = compare_q;
            ti_d      = 1'b1;
         end else begin
            compare_d = compare_q;
            ti_d      = ti_q;
         end
      end
   end

   // Status, Cause.IP[1:0] and EPC; acknowledge overrides eret and software writes
   always_comb begin
      if (wr_status_s) begin
         ie_d = bus.wdata[0];
         im_d = bus.wdata[15:8];
      end else begin
         ie_d = ie_q;
         im_d = im_q;
      end
      if (ack_s) begin
         exl_d = 1'b1;
      end else if (eret_s) begin
         exl_d = 1'b0;
      end else if (wr_status_s) begin
         exl_d = bus.wdata[1];
      end else begin
         exl_d = exl_q;
      end
      if (wr_cause_s) begin
         ip_sw_d = bus.wdata[9:8];
      end else begin
         ip_sw_d = ip_sw_q;
      end
      if (ack_s) begin
         epc_d = bus.epc_in;
      end else if (wr_epc_s) begin
         epc_d = bus.wdata;
      end else begin
         epc_d = epc_q;
      end
   end

   // mfc0 read mux, combinational from reg_addr
   always_comb begin
      case (bus.reg_addr)
         ADDR_COUNT:   rdata_s = TIMER_EN ? count_q : 32'd0;
         ADDR_COMPARE: rdata_s = TIMER_EN ? compare_q : 32'd0;
         ADDR_STATUS:  rdata_s = {16'd0, im_q, 6'd0, exl_q, ie_q};
         ADDR_CAUSE:   rdata_s = {1'b0, timer_ip_s, 14'd0, ip_s, 1'b0, 5'd0, 2'b00};
         ADDR_EPC:     rdata_s = epc_q;
         default:      rdata_s = 32'd0;
      endcase
   end

   assign bus.rdata   = rdata_s;
   assign bus.int_req = int_req_s;

   // State registers with synchronous active-high reset
   always_ff @(posedge clk) begin
      if (rst) begin
         irq_s_q    <= {NUM_IRQ{1'b0}};
         irq_prev_q <= {NUM_IRQ{1'b0}};
         pend_q     <= {NUM_IRQ{1'b0}};
         count_q    <= 32'd0;
         compare_q  <= 32'hFFFF_FFFF;
         epc_q      <= 32'd0;
         ti_q       <= 1'b0;
         ie_q       <= 1'b0;
         exl_q      <= 1'b0;
         im_q       <= 8'd0;
         ip_sw_q    <= 2'b00;
      end else begin
         irq_s_q    <= irq_s_d;
         irq_prev_q <= irq_prev_d;
         pend_q     <= pend_d;
         count_q    <= count_d;
         compare_q  <= compare_d;
         epc_q      <= epc_d;
         ti_q       <= ti_d;
         ie_q       <= ie_d;
         exl_q      <= exl_d;
         im_q       <= im_d;
         ip_sw_q    <= ip_sw_d;
      end
   end

endmodule

// File: doc/cp0_intc.md
Name: cp0_intc

Overview:
- Parametrised coprocessor-0 and interrupt controller for the MIPS150 pipeline. Supersedes the fixed two-source (UART0/UART1) scheme.
- Accepts NUM_IRQ external request lines, each configurable as edge- or level-sensitive, plus a built-in Count/Compare timer.
- Holds Status, Cause, EPC, Count and Compare, which software accesses through mfc0/mtc0.
- Sits beside the execute stage, raises int_req to the fetch logic, and captures the interrupted PC on acknowledge.

Parameters:
- NUM_IRQ, 4, number of external interrupt lines (1..5); line i maps to Cause.IP[2+i].
- EDGE_MASK, {NUM_IRQ{1'b1}}, per-line mode: bit i = 1 means rising-edge latched, 0 means level.
- TIMER_EN, 1, 0 removes Count/Compare; IP[7] then reads 0.

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- stall  in  1  pipeline stall; gates all architectural updates
- irq_in  in  NUM_IRQ  raw interrupt request lines
- reg_addr  in  5  CP0 register number (rd field)
- we  in  1  mtc0 write strobe
- wdata  in  32  mtc0 data
- rdata  out  32  mfc0 data, combinational from reg_addr
- epc_in  in  32  PC to save on acknowledge
- int_ack  in  1  fetch stage has taken the interrupt vector
- eret  in  1  return from interrupt
- int_req  out  1  interrupt pending and enabled

Behaviour:
- Register map: 9 = Count, 11 = Compare, 12 = Status, 13 = Cause, 14 = EPC. Any other address reads 0 and writes are ignored.
- Status fields: bit0 IE, bit1 EXL, bits15:8 IM. All other bits read 0.
- Cause fields: bits15:8 IP, bit30 TI, bits6:2 ExcCode (always 0). All other bits read 0.
- Reset values: Status = 0, Cause = 0, EPC = 0, Count = 0, Compare = 0xFFFFFFFF. Edge-pending bits and irq_prev flops are cleared. rdata follows reg_addr; int_req = 0.
- Input sampling:
  - irq_in is registered once into irq_s every cycle, stall or not.
  - irq_prev <= irq_s every cycle.
  - Because irq_prev resets to 0, a line held high through reset is seen as an edge on the first cycle after reset.
- Edge line i: irq_s[i] & ~irq_prev[i] sets pend[i] on the next edge; this happens even during stall, so no edges are lost. IP[2+i] = pend[i].
- Level line i: IP[2+i] = irq_s[i], live with 1-cycle latency. It is not latched.
- Clearing edge bits: an mtc0 to Cause with IP[2+i] = 0 clears pend[i]; writing 1 has no effect. If a new edge arrives in the same cycle as the clear, the set wins.
- IP[1:0] are software-writable via mtc0 to Cause. IP[7:2] are otherwise read-only.
- Timer:
  - Count increments by 1 every cycle, including during stall, and wraps 0xFFFFFFFF -> 0.
  - mtc0 to Count loads wdata; the increment resumes from that value next cycle.
  - When Count == Compare, TI and IP[7] are set on the following edge and stay set.
  - mtc0 to Compare loads wdata and clears TI/IP[7]. If a match and a Compare write coincide, the write wins.
- Request output: int_req = IE & ~EXL & |(IP & IM). It is combinational from registers, with no extra latency.
- Stall gating: while stall = 1, we, int_ack and eret are ignored. Only irq sampling, pend setting, Count and TI continue to update.
- Acknowledge (int_ack & ~stall & int_req):
  - EPC <= epc_in, EXL <= 1, ExcCode <= 0.
  - int_req therefore drops on the next cycle.
  - int_ack while int_req = 0 is ignored.
- Return (eret & ~stall): EXL <= 0.
- Simultaneous events:
  - int_ack with eret: ack wins, so EXL = 1.
  - int_ack with an mtc0 to Status: the written IE/IM apply but EXL = 1.
  - int_ack with an mtc0 to EPC: epc_in wins.
- Reset mid-operation: everything returns to reset values on the next edge, including a pending or acknowledged interrupt.

Test Plan:
- Edge latch and clear: NUM_IRQ = 4, EDGE_MASK = 4'hF. Write Status = 0x0000_0401, then pulse irq_in[0] for 1 cycle. Expect Cause = 0x0000_0400 and int_req = 1 two cycles after the pulse. Then write Cause = 0. Expect IP[2] = 0 and int_req = 0.
- Level source: EDGE_MASK[1] = 0, IM[3] = 1, IE = 1. Hold irq_in[1] high for 5 cycles. Expect int_req high 1 cycle after assertion and low 1 cycle after release, with no residual pend.
- Acknowledge/eret: with int_req = 1, assert int_ack with epc_in = 0x4000_0124. Expect EPC = 0x4000_0124, Status.EXL = 1 and int_req = 0 next cycle. Then eret; expect int_req to return to 1 while the source is still pending.
- Stall gating: with stall = 1, assert int_ack, we (Status = 0) and a 1-cycle irq_in[2] edge. Expect Status and EPC unchanged and pend[2] set. After stall falls, int_req is asserted if IM[4] = 1.
- Timer: write Count = 0xFFFF_FFFE and Compare = 0x0000_0001, with IM[7] = 1 and IE = 1. Expect Count to wrap to 0, IP[7] = 1 one cycle after Count == 1, and int_req = 1. Writing Compare = 0x100 clears IP[7].
- Races: an edge on irq_in[0] coinciding with a Cause clear write leaves pend[0] = 1. int_ack together with eret leaves EXL = 1.
